// File: rtl/sfm_fp_stream_minmax_acc.sv
// Streaming FP min/max reducer: per-beat lane reduction folded into a running
// accumulator, returning the extremum and its global element index.
module sfm_fp_stream_minmax_acc #(
   parameter int unsigned EXP_BITS   = 8,   // 8/7 = FP16ALT (bfloat16)
   parameter int unsigned MAN_BITS   = 7,
   parameter int unsigned VECT_WIDTH = 4,
   parameter int unsigned CNT_WIDTH  = 16,
   localparam int unsigned WIDTH     = 1 + EXP_BITS + MAN_BITS
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        clear_i,
   input  logic                        valid_i,
   output logic                        ready_o,
   input  logic                        last_i,
   input  logic [VECT_WIDTH-1:0]       strb_i,
   input  logic [VECT_WIDTH*WIDTH-1:0] vect_i,
   input  logic                        mode_i,   // 0 = MIN, 1 = MAX
   output logic                        valid_o,
   input  logic                        ready_i,
   output logic [WIDTH-1:0]            res_o,
   output logic [CNT_WIDTH-1:0]        idx_o,
   output logic                        strb_o,
   output logic                        ovf_o
);

   localparam int unsigned LANE_W = (VECT_WIDTH > 1) ? $clog2(VECT_WIDTH) : 1;
   localparam int unsigned IW     = CNT_WIDTH + LANE_W + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ACC  = 2'd1;
   localparam logic [1:0] OUT  = 2'd2;

   localparam logic [WIDTH-1:0] CANON_NAN =
      {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MAN_BITS-1){1'b0}}};

   // Maps FP bits onto an unsigned key whose order is the IEEE total order
   // (-0 below +0), so one unsigned compare serves both signs.
   function automatic logic [WIDTH-1:0] order_key(input logic [WIDTH-1:0] x);
      return x[WIDTH-1] ? ~x : {1'b1, x[WIDTH-2:0]};
   endfunction

   logic [1:0]                         state_q;
   logic                               mode_q;
   logic [CNT_WIDTH-1:0]               beat_cnt_q;
   logic                               acc_vld_q;
   logic [WIDTH-1:0]                   acc_val_q;
   logic [CNT_WIDTH-1:0]               acc_idx_q;
   logic                               acc_ovf_q;

   logic [VECT_WIDTH-1:0][WIDTH-1:0]   lanes;
   logic [VECT_WIDTH-1:0][WIDTH-1:0]   lane_key;
   logic [VECT_WIDTH-1:0]              lane_ok;

   logic                               use_max;
   logic                               beat_vld;
   logic [WIDTH-1:0]                   beat_val;
   logic [WIDTH-1:0]                   beat_key;
   logic [LANE_W-1:0]                  beat_lane;

   logic [IW-1:0]                      base_w;
   logic [IW-1:0]                      last_w;
   logic                               beat_ovf;
   logic [CNT_WIDTH-1:0]               beat_idx;

   logic                               acc_live;
   logic [WIDTH-1:0]                   acc_key;
   logic                               take_beat;
   logic                               nxt_vld;
   logic [WIDTH-1:0]                   nxt_val;
   logic [CNT_WIDTH-1:0]               nxt_idx;
   logic                               nxt_ovf;

   assign lanes   = vect_i;
   assign ready_o = (state_q != OUT);
   assign valid_o = (state_q == OUT);
   assign use_max = (state_q == IDLE) ? mode_i : mode_q;

   for (genvar g = 0; g < VECT_WIDTH; g++) begin : g_lane
      assign lane_ok[g]  = strb_i[g] &&
                           !(&lanes[g][WIDTH-2:MAN_BITS] && |lanes[g][MAN_BITS-1:0]);
      assign lane_key[g] = order_key(lanes[g]);
   end

   // Strict compare: an equal later lane never displaces an earlier one.
   always_comb begin
      beat_vld  = 1'b0;
      beat_val  = '0;
      beat_key  = '0;
      beat_lane = '0;
      for (int unsigned i = 0; i < VECT_WIDTH; i++) begin
         if (lane_ok[i] && (!beat_vld ||
             (use_max ? (lane_key[i] > beat_key) : (lane_key[i] < beat_key)))) begin
            beat_vld  = 1'b1;
            beat_val  = lanes[i];
            beat_key  = lane_key[i];
            beat_lane = LANE_W'(i);
         end
      end
   end

   // Overflow is flagged as soon as any index of the beat leaves the range.
   assign base_w   = IW'(beat_cnt_q) * IW'(VECT_WIDTH);
   assign last_w   = base_w + IW'(VECT_WIDTH - 1);
   assign beat_ovf = |last_w[IW-1:CNT_WIDTH];
   assign beat_idx = base_w[CNT_WIDTH-1:0] + CNT_WIDTH'(beat_lane);

   assign acc_live  = (state_q == ACC) && acc_vld_q;
   assign acc_key   = order_key(acc_val_q);
   assign take_beat = beat_vld && (!acc_live ||
                      (use_max ? (beat_key > acc_key) : (beat_key < acc_key)));
   assign nxt_vld   = acc_live || beat_vld;
   assign nxt_val   = take_beat ? beat_val : acc_val_q;
   assign nxt_idx   = take_beat ? beat_idx : acc_idx_q;
   assign nxt_ovf   = ((state_q == ACC) && acc_ovf_q) || beat_ovf;

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         state_q    <= IDLE;
         mode_q     <= 1'b0;
         beat_cnt_q <= '0;
         acc_vld_q  <= 1'b0;
         acc_val_q  <= '0;
         acc_idx_q  <= '0;
         acc_ovf_q  <= 1'b0;
         res_o      <= '0;
         idx_o      <= '0;
         strb_o     <= 1'b0;
         ovf_o      <= 1'b0;
      end else begin
         case (state_q)
            IDLE, ACC: begin
               if (valid_i) begin
                  if (state_q == IDLE) mode_q <= mode_i;
                  acc_vld_q <= nxt_vld;
                  acc_val_q <= nxt_val;
                  acc_idx_q <= nxt_idx;
                  acc_ovf_q <= nxt_ovf;
                  if (last_i) begin
                     state_q    <= OUT;
                     beat_cnt_q <= '0;
                     res_o      <= nxt_vld ? nxt_val : CANON_NAN;
                     idx_o      <= nxt_vld ? nxt_idx : '0;
                     strb_o     <= nxt_vld;
                     ovf_o      <= nxt_ovf;
                  end else begin
                     state_q    <= ACC;
                     beat_cnt_q <= beat_cnt_q + CNT_WIDTH'(1);
                  end
               end
            end
            OUT: begin
               if (ready_i) begin
                  state_q   <= IDLE;
                  acc_vld_q <= 1'b0;
                  acc_ovf_q <= 1'b0;
                  ovf_o     <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sfm_fp_stream_minmax_acc.sv
// Scoreboard bench for sfm_fp_stream_minmax_acc (bfloat16, 4 lanes, 16-bit index).
module tb_sfm_fp_stream_minmax_acc;

   localparam int VW = 4;

   typedef struct packed {
      logic [15:0] res;
      logic [15:0] idx;
      logic        strb;
      logic        ovf;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_i, clear_i, valid_i, ready_o, last_i, mode_i;
   logic        valid_o, ready_i, strb_o, ovf_o;
   logic [3:0]  strb_i;
   logic [63:0] vect_i;
   logic [15:0] res_o, idx_o;

   int checks = 0;
   int errors = 0;

   res_t        exp_q[$];
   logic [63:0] bv[$];
   logic [3:0]  bs[$];
   bit          cur_mx;

   sfm_fp_stream_minmax_acc #(
      .EXP_BITS(8), .MAN_BITS(7), .VECT_WIDTH(VW), .CNT_WIDTH(16)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .valid_i(valid_i),
      .ready_o(ready_o), .last_i(last_i), .strb_i(strb_i), .vect_i(vect_i),
      .mode_i(mode_i), .valid_o(valid_o), .ready_i(ready_i), .res_o(res_o),
      .idx_o(idx_o), .strb_o(strb_o), .ovf_o(ovf_o)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   function automatic bit is_nan(input logic [15:0] x);
      return (x[14:7] == 8'hFF) && (x[6:0] != 7'd0);
   endfunction

   // a < b under the IEEE total order, sign/magnitude reasoning
   function automatic bit lt(input logic [15:0] a, input logic [15:0] b);
      if (a == b) return 1'b0;
      if (a[15] != b[15]) return a[15];
      if (!a[15]) return a[14:0] < b[14:0];
      return a[14:0] > b[14:0];
   endfunction

   function automatic res_t model(input bit mx);
      res_t        r;
      bit          found = 1'b0;
      logic [15:0] best = '0;
      logic [15:0] x;
      logic [63:0] vv;
      int          bi = 0;
      for (int b = 0; b < bv.size(); b++) begin
         vv = bv[b];
         for (int l = 0; l < VW; l++) begin
            x = vv[l*16 +: 16];
            if (bs[b][l] && !is_nan(x) && (!found || (mx ? lt(best, x) : lt(x, best)))) begin
               found = 1'b1;
               best  = x;
               bi    = b * VW + l;
            end
         end
      end
      r.res  = found ? best : 16'h7FC0;
      r.idx  = found ? 16'(bi) : 16'd0;
      r.strb = found;
      r.ovf  = (bv.size() * VW > 65536);
      return r;
   endfunction

   // Presents one beat until accepted (bounded), then records it for the model.
   task automatic beat(input logic [63:0] v, input logic [3:0] s, input bit last, input bit mx);
      bit took = 1'b0;
      int tries = 0;
      valid_i = 1'b1; vect_i = v; strb_i = s; last_i = last; mode_i = mx;
      while (!took && tries < 8) begin
         took = ready_o;
         @(posedge clk); #1;
         tries++;
      end
      valid_i = 1'b0; last_i = 1'b0;
      if (!took) begin
         checks++; errors++;
         $display("FAIL beat_accept timed out, ready_o stayed %b want 1", ready_o);
      end else begin
         if (bv.size() == 0) cur_mx = mx;
         bv.push_back(v);
         bs.push_back(s);
         if (last) begin
            exp_q.push_back(model(cur_mx));
            bv.delete(); bs.delete();
         end
      end
   endtask

   task automatic handshake();
      ready_i = 1'b1;
      @(posedge clk); #1;
      ready_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; clear_i = 1'b0; valid_i = 1'b0; last_i = 1'b0;
      strb_i = '0; vect_i = '0; mode_i = 1'b0; ready_i = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_i = 1'b0;
      checks++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
         errors++; $display("FAIL reset_hs valid_o=%b ready_o=%b want 0 1", valid_o, ready_o);
      end
      checks++;
      if ({res_o, idx_o, strb_o, ovf_o} !== 34'd0) begin
         errors++; $display("FAIL reset_data res=%h idx=%0d strb=%b ovf=%b want all 0", res_o, idx_o, strb_o, ovf_o);
      end
   endtask

   task automatic test_single_max();
      res_t e;
      beat(64'h3F00_C040_4000_3F80, 4'hF, 1'b1, 1'b1);
      e = exp_q.size() ? exp_q.pop_front() : '0;
      checks++;
      if (valid_o !== 1'b1 || {res_o, idx_o, strb_o} !== {16'h4000, 16'd1, 1'b1}) begin
         errors++; $display("FAIL single_const v=%b res=%h idx=%0d strb=%b want 1 4000 1 1", valid_o, res_o, idx_o, strb_o);
      end
      checks++;
      if ({res_o, idx_o, strb_o, ovf_o} !== {e.res, e.idx, e.strb, e.ovf}) begin
         errors++; $display("FAIL single_model res=%h idx=%0d want %h %0d", res_o, idx_o, e.res, e.idx);
      end
      handshake();
   endtask

   // MIN latched on beat 0; later beats present MAX, which must be ignored.
   task automatic test_multi_min();
      res_t e;
      beat(64'h4040_3F00_4000_3F80, 4'hF, 1'b0, 1'b0);
      beat(64'h0000_3F80_4000_BF80, 4'hF, 1'b0, 1'b1);
      checks++;
      if (valid_o !== 1'b0) begin
         errors++; $display("FAIL multi_early_valid valid_o=%b want 0", valid_o);
      end
      beat(64'hC040_3F80_BF80_4000, 4'hF, 1'b1, 1'b1);
      e = exp_q.size() ? exp_q.pop_front() : '0;
      checks++;
      if (valid_o !== 1'b1 || res_o !== 16'hC040 || idx_o !== 16'd11) begin
         errors++; $display("FAIL multi_const v=%b res=%h idx=%0d want 1 c040 11", valid_o, res_o, idx_o);
      end
      checks++;
      if ({res_o, idx_o, strb_o, ovf_o} !== {e.res, e.idx, e.strb, e.ovf}) begin
         errors++; $display("FAIL multi_model res=%h idx=%0d want %h %0d", res_o, idx_o, e.res, e.idx);
      end
      handshake();
   endtask

   task automatic test_ties();
      beat(64'h3F80_4000_3F80_0000, 4'hF, 1'b0, 1'b1);
      beat(64'h0000_0000_3F80_4000, 4'hF, 1'b1, 1'b1);
      void'(exp_q.pop_front());
      checks++;
      if (valid_o !== 1'b1 || res_o !== 16'h4000 || idx_o !== 16'd2) begin
         errors++; $display("FAIL tie_idx v=%b res=%h idx=%0d want 1 4000 2", valid_o, res_o, idx_o);
      end
      handshake();
      beat(64'h4100_4100_0000_8000, 4'b0011, 1'b1, 1'b1);
      void'(exp_q.pop_front());
      checks++;
      if (res_o !== 16'h0000 || idx_o !== 16'd1) begin
         errors++; $display("FAIL zero_max res=%h idx=%0d want 0000 1", res_o, idx_o);
      end
      handshake();
      beat(64'h4100_4100_8000_0000, 4'b0011, 1'b1, 1'b0);
      void'(exp_q.pop_front());
      checks++;
      if (res_o !== 16'h8000 || idx_o !== 16'd1) begin
         errors++; $display("FAIL zero_min res=%h idx=%0d want 8000 1", res_o, idx_o);
      end
      handshake();
   endtask

   task automatic test_empty();
      beat(64'h7FC0_7F81_FFC0_7FC1, 4'hF, 1'b0, 1'b1);
      beat(64'h4000_4000_4000_4000, 4'h0, 1'b1, 1'b1);
      void'(exp_q.pop_front());
      checks++;
      if (valid_o !== 1'b1 || {res_o, idx_o, strb_o} !== {16'h7FC0, 16'd0, 1'b0}) begin
         errors++; $display("FAIL empty v=%b res=%h idx=%0d strb=%b want 1 7fc0 0 0", valid_o, res_o, idx_o, strb_o);
      end
      handshake();
      beat(64'hFFC0_7FFF_3F80_7FC0, 4'hF, 1'b1, 1'b1);
      void'(exp_q.pop_front());
      checks++;
      if ({res_o, idx_o, strb_o} !== {16'h3F80, 16'd1, 1'b1}) begin
         errors++; $display("FAIL nan_mix res=%h idx=%0d strb=%b want 3f80 1 1", res_o, idx_o, strb_o);
      end
      handshake();
      beat(64'h4000_4000_4000_4000, 4'h0, 1'b0, 1'b1);
      beat(64'h0000_3F80_0000_0000, 4'b0100, 1'b1, 1'b1);
      void'(exp_q.pop_front());
      checks++;
      if ({res_o, idx_o, strb_o} !== {16'h3F80, 16'd6, 1'b1}) begin
         errors++; $display("FAIL empty_beat_idx res=%h idx=%0d strb=%b want 3f80 6 1", res_o, idx_o, strb_o);
      end
      handshake();
   endtask

   task automatic test_backpressure();
      void'(exp_q.size());
      beat(64'h3F00_C040_4000_3F80, 4'hF, 1'b1, 1'b1);
      void'(exp_q.pop_front());
      valid_i = 1'b1; last_i = 1'b1; vect_i = 64'h4100_4100_4100_4100; strb_i = 4'hF;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (valid_o !== 1'b1 || ready_o !== 1'b0 || res_o !== 16'h4000 || idx_o !== 16'd1) begin
            errors++; $display("FAIL bp_hold cyc=%0d v=%b rdy=%b res=%h idx=%0d want 1 0 4000 1", i, valid_o, ready_o, res_o, idx_o);
         end
         @(posedge clk); #1;
      end
      valid_i = 1'b0; last_i = 1'b0;
      handshake();
      checks++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
         errors++; $display("FAIL bp_release rdy=%b v=%b want 1 0", ready_o, valid_o);
      end
      repeat (2) @(posedge clk); #1;
      checks++;
      if (valid_o !== 1'b0) begin
         errors++; $display("FAIL bp_phantom v=%b want 0", valid_o);
      end
   endtask

   task automatic test_clear();
      beat(64'h0000_0000_0000_4100, 4'hF, 1'b0, 1'b1);
      beat(64'h0000_0000_0000_4100, 4'hF, 1'b0, 1'b1);
      clear_i = 1'b1;
      @(posedge clk); #1;
      clear_i = 1'b0;
      bv.delete(); bs.delete();
      checks++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
         errors++; $display("FAIL clear_state v=%b rdy=%b want 0 1", valid_o, ready_o);
      end
      beat(64'h3F80_0000_0000_0000, 4'b1000, 1'b1, 1'b1);
      void'(exp_q.pop_front());
      checks++;
      if (valid_o !== 1'b1 || res_o !== 16'h3F80 || idx_o !== 16'd3) begin
         errors++; $display("FAIL clear_fresh v=%b res=%h idx=%0d want 1 3f80 3", valid_o, res_o, idx_o);
      end
      // reset while a result is pending
      rst_i = 1'b1;
      @(posedge clk); #1;
      rst_i = 1'b0;
      checks++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1 || {res_o, idx_o, strb_o} !== 33'd0) begin
         errors++; $display("FAIL rst_out v=%b rdy=%b res=%h idx=%0d strb=%b want 0 1 0 0 0", valid_o, ready_o, res_o, idx_o, strb_o);
      end
      beat(64'h0000_4000_0000_0000, 4'hF, 1'b1, 1'b1);
      void'(exp_q.pop_front());
      checks++;
      if (res_o !== 16'h4000 || idx_o !== 16'd2) begin
         errors++; $display("FAIL rst_fresh res=%h idx=%0d want 4000 2", res_o, idx_o);
      end
      handshake();
   endtask

   task automatic test_back_to_back();
      logic [15:0] pool [11] = '{16'h0000, 16'h8000, 16'h3F80, 16'hBF80, 16'h4000,
                                 16'hC040, 16'h7FC0, 16'hFFC1, 16'h7F80, 16'hFF80, 16'h4000};
      logic [63:0] v;
      res_t        e;
      int          len;
      ready_i = 1'b1;
      for (int r = 0; r < 20; r++) begin
         len = $urandom_range(1, 4);
         for (int b = 0; b < len; b++) begin
            for (int l = 0; l < VW; l++) v[l*16 +: 16] = pool[$urandom_range(0, 10)];
            beat(v, 4'($urandom_range(0, 15)), b == len - 1, 1'($urandom_range(0, 1)));
         end
         e = exp_q.size() ? exp_q.pop_front() : '0;
         checks++;
         if (valid_o !== 1'b1 || {res_o, idx_o, strb_o, ovf_o} !== {e.res, e.idx, e.strb, e.ovf}) begin
            errors++; $display("FAIL b2b r=%0d v=%b res=%h idx=%0d strb=%b want 1 %h %0d %b", r, valid_o, res_o, idx_o, strb_o, e.res, e.idx, e.strb);
         end
      end
      @(posedge clk); #1;
      ready_i = 1'b0;
   endtask

   task automatic test_overflow();
      res_t e;
      for (int n = 16384; n <= 16385; n++) begin
         beat(64'h0000_0000_0000_3F80, 4'b0001, 1'b0, 1'b1);
         for (int b = 1; b < n; b++) beat(64'h0, 4'h0, b == n - 1, 1'b1);
         e = exp_q.size() ? exp_q.pop_front() : '0;
         checks++;
         if (valid_o !== 1'b1 || ovf_o !== (n == 16385) || {res_o, strb_o, ovf_o} !== {e.res, e.strb, e.ovf}) begin
            errors++; $display("FAIL ovf n=%0d v=%b res=%h strb=%b ovf=%b want 1 %h %b %b", n, valid_o, res_o, strb_o, ovf_o, e.res, e.strb, e.ovf);
         end
         if (!e.ovf) begin
            checks++;
            if (idx_o !== e.idx) begin
               errors++; $display("FAIL ovf_edge_idx idx=%0d want %0d", idx_o, e.idx);
            end
         end
         handshake();
      end
   endtask

   initial begin
      test_reset();
      test_single_max();
      test_multi_min();
      test_ties();
      test_empty();
      test_backpressure();
      test_clear();
      test_back_to_back();
      test_overflow();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sfm_fp_stream_minmax_acc.md
Name: sfm_fp_stream_minmax_acc

Overview:
- Streaming min/max reducer for the softmax datapath. It reduces a multi-beat stream of VECT_WIDTH-lane FP vectors into one scalar extremum plus the global index (argmin/argmax) of that element.
- Each beat is first reduced by an internal lane tree; the beat result is then folded into a running accumulator until a beat flagged last_i.
- The block feeds the max-subtraction stage and any downstream logic that needs the argmax position.

Parameters:
- FPFORMAT, fpnew_pkg::FP16ALT: element FP format; WIDTH = fpnew_pkg::fp_width(FPFORMAT).
- VECT_WIDTH, 4: lanes per beat; ≥1, any value (non-power-of-two allowed).
- CNT_WIDTH, 16: width of the global element index output.

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: synchronous active-high reset.
- clear_i, in, 1: synchronous flush. Same effect as rst_i.
- valid_i, in, 1: input beat valid.
- ready_o, out, 1: input beat accepted when valid_i && ready_o.
- last_i, in, 1: the accepted beat closes the reduction.
- strb_i, in, VECT_WIDTH: per-lane enable. Disabled lanes are ignored but still consume an index.
- vect_i, in, VECT_WIDTH*WIDTH: packed lanes; lane 0 is in the LSBs.
- mode_i, in, sfm_pkg::min_max_mode_t: MIN or MAX. Sampled on the first beat of a reduction.
- valid_o, out, 1: result valid.
- ready_i, in, 1: downstream ready.
- res_o, out, WIDTH: reduced extremum.
- idx_o, out, CNT_WIDTH: global index of res_o.
- strb_o, out, 1: at least one non-NaN enabled element was seen.
- ovf_o, out, 1: element count exceeded 2^CNT_WIDTH.

Behaviour:
- Reset/clear:
  - State = IDLE; valid_o = 0; res_o = 0; idx_o = 0; strb_o = 0; ovf_o = 0.
  - Beat counter = 0; accumulator empty.
  - clear_i mid-reduction or while in OUT discards all partial state and drops any pending result without a handshake.
  - rst_i and clear_i have priority over every other event in the same cycle.
- States:
  - IDLE: ready_o = 1. An accepted beat loads the accumulator with the beat result and latches mode_i. Next state is OUT if last_i is set, otherwise ACC.
  - ACC: ready_o = 1. Each accepted beat is merged into the accumulator using the latched mode; mode_i is ignored. last_i on an accepted beat moves to OUT.
  - OUT: ready_o = 0; valid_o = 1. Outputs are held stable while ready_i = 0. On valid_o && ready_i, the block returns to IDLE and the counter resets.
- Latency: valid_o rises the cycle after the last beat is accepted. Throughput is one beat per cycle during accumulation, with one bubble per reduction (no input accepted while in OUT).
- Index:
  - Element index = beat_count*VECT_WIDTH + lane.
  - beat_count counts accepted beats of the current reduction.
  - If the index would exceed 2^CNT_WIDTH-1, ovf_o sets and stays set until the result handshake. idx_o is then undefined but stable.
- Comparison rules:
  - IEEE total order on non-NaN values, with -0 < +0.
  - NaN lanes are ignored (minNum/maxNum semantics).
  - Ties are broken by the lowest index: a strict comparison is used in the tree and in the accumulator, so the earlier element always wins.
- Empty result: if no enabled non-NaN element was seen, strb_o = 0, res_o = canonical NaN of FPFORMAT (0x7FC0 for FP16ALT), and idx_o = 0.
- Beat with no valid lanes (strb_i = 0 or all NaN): the accumulator is unchanged, but the counter still advances.
- Beat with last_i arriving in IDLE: single-beat reduction; the result is valid on the next cycle.
- Mode changes on mode_i in the middle of a reduction have no effect.

Test Plan:
- FP16ALT, VECT_WIDTH=4, MAX, one beat {0x3F80, 0x4000, 0xC040, 0x3F00} with last_i -> next cycle valid_o=1, res_o=0x4000, idx_o=1, strb_o=1.
- Same format, MIN, three beats with a -3.0 (0xC040) in beat 2 lane 3, last_i on beat 3 -> res_o=0xC040, idx_o=11, valid_o exactly one cycle after the third accept.
- Tie: MAX, 2.0 in beat 0 lane 2 and in beat 1 lane 0 -> idx_o=2. Also -0 (0x8000) vs +0 (0x0000) under MAX -> res_o=0x0000.
- Empty result: every enabled lane NaN, or strb_i=0, for 2 beats -> strb_o=0, res_o=0x7FC0, idx_o=0. Also NaN mixed with 1.0 -> res_o=0x3F80.
- Backpressure: hold ready_i=0 for 5 cycles in OUT -> ready_o=0, outputs stable, no input accepted. After the handshake -> IDLE and ready_o=1 the next cycle.
- clear_i asserted mid-ACC (after 2 beats) -> next cycle IDLE with no valid_o. A fresh 1-beat reduction then yields indices starting at 0. Repeat the check with rst_i asserted while in OUT.
